// File: rtl/dmem_responder.sv
// Data-memory responder: byte-lane writes, registered reads, range check, and a
// sequential clear engine that zeroes the whole array after every reset.
module dmem_responder #(
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned AW    = 10
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          mem_rw_mode,
   input  logic [AW-1:0] mem_addr,
   input  logic [31:0]   mem_write_data,
   input  logic [3:0]    mem_byte_en,
   output logic [31:0]   mem_read_data,
   output logic          mem_busy,
   output logic          mem_err
);

   localparam int unsigned CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {StClear, StIdle} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] clr_cnt_q, clr_cnt_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          err_q, err_d;

   logic [31:0]   mem_q [DEPTH];

   logic          in_range;
   logic [CW-1:0] idx;
   logic [31:0]   cur_word;
   logic [31:0]   merged;
   logic          wr_en;
   logic [CW-1:0] wr_idx;
   logic [31:0]   wr_data;

   // Range check on the full address before truncating it to an array index.
   always_comb begin
      in_range = ({1'b0, mem_addr} < (AW+1)'(DEPTH));
      idx      = mem_addr[CW-1:0];
      cur_word = mem_q[idx];
      for (int i = 0; i < 4; i++) begin
         merged[8*i +: 8] = mem_byte_en[i] ? mem_write_data[8*i +: 8] : cur_word[8*i +: 8];
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      rdata_d   = '0;
      err_d     = err_q;
      wr_en     = 1'b0;
      wr_idx    = idx;
      wr_data   = merged;
      unique case (state_q)
         StClear: begin
            wr_en   = 1'b1;
            wr_idx  = clr_cnt_q;
            wr_data = '0;
            if (clr_cnt_q == CW'(DEPTH - 1)) begin
               state_d = StIdle;
            end else begin
               clr_cnt_d = clr_cnt_q + 1'b1;
            end
         end
         StIdle: begin
            if (!in_range) begin
               err_d = 1'b1;
            end else if (mem_rw_mode) begin
               wr_en   = 1'b1;
               rdata_d = merged;
            end else begin
               rdata_d = cur_word;
            end
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q   <= StClear;
         clr_cnt_q <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
      end
   end

   // Array has no reset; the clear engine is what zeroes it.
   always_ff @(posedge i_clk) begin
      if (wr_en) begin
         mem_q[wr_idx] <= wr_data;
      end
   end

   assign mem_read_data = rdata_q;
   assign mem_busy      = (state_q == StClear);
   assign mem_err       = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (DEPTH 1024 and 512) on shared stimulus,
// checked every cycle against an array-based reference model.
module tb_dmem_responder;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        rw;
   logic [9:0]  addr;
   logic [31:0] wdata;
   logic [3:0]  be;

   logic [31:0] rd_big, rd_sml;
   logic        busy_big, busy_sml, err_big, err_sml;

   int n_pass  = 0;
   int n_total = 0;

   logic [31:0] m [2][1024];
   int unsigned dep [2] = '{1024, 512};
   int          clr_left [2];
   logic [31:0] exp_rd [2];
   bit          exp_err [2];
   bit          rd_known [2];

   always #5 i_clk = ~i_clk;

   dmem_responder #(.DEPTH(1024), .AW(10)) u_big (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .mem_rw_mode    (rw),
      .mem_addr       (addr),
      .mem_write_data (wdata),
      .mem_byte_en    (be),
      .mem_read_data  (rd_big),
      .mem_busy       (busy_big),
      .mem_err        (err_big)
   );

   dmem_responder #(.DEPTH(512), .AW(10)) u_sml (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .mem_rw_mode    (rw),
      .mem_addr       (addr),
      .mem_write_data (wdata),
      .mem_byte_en    (be),
      .mem_read_data  (rd_sml),
      .mem_busy       (busy_sml),
      .mem_err        (err_sml)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic check_all();
      chk("busy_big", 32'(busy_big), 32'(clr_left[0] > 0));
      chk("busy_sml", 32'(busy_sml), 32'(clr_left[1] > 0));
      chk("err_big", 32'(err_big), 32'(exp_err[0]));
      chk("err_sml", 32'(err_sml), 32'(exp_err[1]));
      if (rd_known[0]) chk("rd_big", rd_big, exp_rd[0]);
      if (rd_known[1]) chk("rd_sml", rd_sml, exp_rd[1]);
   endtask

   // One rising edge of behaviour for both memories.
   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         if (i_rst) begin
            if (clr_left[k] > 0) begin
               clr_left[k]--;
               exp_rd[k]   = '0;
               rd_known[k] = 1'b1;
               if (clr_left[k] == 0) begin
                  for (int j = 0; j < 1024; j++) m[k][j] = '0;
               end
            end else if (32'(addr) >= dep[k]) begin
               exp_err[k]  = 1'b1;
               exp_rd[k]   = '0;
               rd_known[k] = !rw;
            end else begin
               if (rw) begin
                  for (int l = 0; l < 4; l++) begin
                     if (be[l]) m[k][addr][8*l +: 8] = wdata[8*l +: 8];
                  end
               end
               exp_rd[k]   = m[k][addr];
               rd_known[k] = 1'b1;
            end
         end
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic op(input bit w, input int a, input logic [31:0] d, input logic [3:0] b);
      rw    = w;
      addr  = 10'(a);
      wdata = d;
      be    = b;
      step();
   endtask

   // Asserts reset for two edges and leaves it asserted.
   task automatic apply_reset();
      i_rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         clr_left[k] = int'(dep[k]);
         exp_rd[k]   = '0;
         exp_err[k]  = 1'b0;
         rd_known[k] = 1'b1;
      end
      #1;
      check_all();
      step();
      step();
   endtask

   task automatic release_reset();
      @(negedge i_clk);
      i_rst = 1'b1;
   endtask

   task automatic count_busy(input int start, output int cnt);
      cnt = start;
      while (busy_big && cnt < 3000) begin
         step();
         cnt++;
      end
   endtask

   int cnt;

   initial begin
      rw    = 1'b0;
      addr  = '0;
      wdata = '0;
      be    = '0;
      apply_reset();
      chk("reset_busy", 32'(busy_big), 32'd1);
      chk("reset_rd", rd_big, 32'h0);
      release_reset();

      // Write during the clear is dropped.
      op(1'b1, 7, 32'h11111111, 4'b1111);
      rw = 1'b0;
      count_busy(1, cnt);
      chk("clear_len", 32'(cnt), 32'd1024);

      op(1'b0, 0, 32'h0, 4'h0);
      chk("rd0_big", rd_big, 32'h0);
      chk("rd0_sml", rd_sml, 32'h0);
      op(1'b0, 511, 32'h0, 4'h0);
      chk("rd511_big", rd_big, 32'h0);
      chk("err_sml_clean", 32'(err_sml), 32'd0);

      op(1'b1, 5, 32'hDEADBEEF, 4'b1111);
      chk("wr5_first", rd_big, 32'hDEADBEEF);
      op(1'b0, 5, 32'h0, 4'h0);
      chk("rd5", rd_big, 32'hDEADBEEF);
      op(1'b1, 5, 32'h00001200, 4'b0010);
      chk("wr5_lane1", rd_big, 32'hDEAD12EF);
      op(1'b1, 5, 32'hFFFFFFFF, 4'b0000);
      chk("wr5_noop", rd_big, 32'hDEAD12EF);
      op(1'b0, 5, 32'h0, 4'h0);
      chk("rd5_after", rd_sml, 32'hDEAD12EF);

      op(1'b1, 600, 32'hCAFEF00D, 4'b1111);
      chk("oor_err_sml", 32'(err_sml), 32'd1);
      chk("oor_err_big", 32'(err_big), 32'd0);
      op(1'b0, 88, 32'h0, 4'h0);
      chk("no_alias_88", rd_sml, 32'h0);
      op(1'b0, 600, 32'h0, 4'h0);
      chk("oor_rd_sml", rd_sml, 32'h0);
      chk("rd600_big", rd_big, 32'hCAFEF00D);
      chk("err_sticky", 32'(err_sml), 32'd1);
      op(1'b0, 1023, 32'h0, 4'h0);
      chk("rd1023_big", rd_big, 32'h0);
      op(1'b0, 7, 32'h0, 4'h0);
      chk("rd7_dropped", rd_big, 32'h0);

      for (int i = 0; i < 400; i++) begin
         int a;
         a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023))
                                         : int'($urandom_range(0, 15));
         op(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
      end

      // Reset mid-clear restarts a full clear and wipes earlier contents.
      rw = 1'b0;
      apply_reset();
      chk("err_cleared", 32'(err_sml), 32'd0);
      release_reset();
      for (int i = 0; i < 300; i++) step();
      apply_reset();
      release_reset();
      count_busy(0, cnt);
      chk("reclear_len", 32'(cnt), 32'd1024);
      op(1'b0, 5, 32'h0, 4'h0);
      chk("rd5_wiped", rd_big, 32'h0);
      op(1'b0, 600, 32'h0, 4'h0);
      chk("rd600_wiped", rd_big, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
